chan_mux_rr: RTL and testbench
==============================

// Module: chan_mux_rr
// PURPOSE
//  Parametrised N:1 channel multiplexer, successor to the 4:1 bit mux. It selects one
//  of N W-bit streams into a single registered output with valid/ready handshake.
//  Selection is either fixed (external sel) or round-robin among valid channels.
//  It sits between per-channel producers and a shared downstream consumer.
// PARAMETERS
//  N      4   number of input channels, 2..16, need not be a power of two
//  W      8   data width per channel, >=1
//  SW     $clog2(N)  select/channel-index width (derived localparam, not overridable)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  mode       in   1      0 = FIXED (use sel), 1 = RR (round-robin)
//  sel        in   SW     channel index used in FIXED mode
//  in_data    in   N*W    channel c occupies bits [c*W +: W]
//  in_valid   in   N      per-channel valid
//  in_ready   out  N      per-channel ready, at most one bit high per cycle
//  out_data   out  W      registered selected data
//  out_chan   out  SW     index of the channel that supplied out_data
//  out_valid  out  1      output holds a beat
//  out_ready  in   1      downstream accepts the beat
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr ptr=0.
//  - One output register stage. take = ~out_valid | out_ready (stage free this cycle).
//  - Grant g (combinational): FIXED: g=sel if sel<N and in_valid[sel]; RR: first c with
//    in_valid[c], searching ptr, ptr+1, ... wrapping mod N. No valid candidate -> no grant.
//  - in_ready[g] = take when a grant exists; all other in_ready bits 0. in_ready does not
//    depend on in_valid of non-granted channels only via the arbiter (no combinational
//    path from out_ready to in_valid).
//  - Accept (grant & take): next cycle out_data=in_data[g], out_chan=g, out_valid=1.
//  - take & no grant: out_valid<=0. ~take: out_data/out_chan/out_valid held unchanged.
//  - Latency 1 cycle input->output; throughput 1 beat/cycle with out_ready held high.
//  - RR pointer: on accept in RR mode ptr <= (g==N-1) ? 0 : g+1. Unchanged in FIXED mode
//    and when no accept occurs.
//  - sel >= N (non-power-of-two N) in FIXED mode: no grant, all in_ready=0, no error flag.
//  - mode or sel change while out_valid=1 and stalled: held beat unaffected; new selection
//    applies from the next accept. Switching FIXED->RR resumes from the stored ptr.
//  - Simultaneous out_ready and new grant: old beat leaves, new beat loads same edge.
//  - Reset mid-transfer: held beat is dropped; producers must re-present data.
// STRUCTURE
//  - Package chan_mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1 constants.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr[SW]; outputs gnt_vld, gnt_idx[SW].
//    Pure combinational, double-width priority search; ptr register lives in chan_mux_rr.
//  - Top: grant mux (FIXED vs rr_arbiter), in_ready decode, output register, ptr register.
// TESTING (N=4, W=8 unless noted)
//  1 Reset: rst_n low mid-run with out_valid=1 -> out_valid=0, out_data=0, out_chan=0
//    immediately, without waiting for clk.
//  2 FIXED: mode=0, sel=2, in_data ch2=8'hA5, all valid, out_ready=1 -> next cycle
//    out_data=A5, out_chan=2; in_ready=4'b0100 every cycle.
//  3 RR: all four valid, out_ready=1 -> out_chan sequence 0,1,2,3,0,...; with only ch1,ch3
//    valid -> 1,3,1,3.
//  4 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_chan stable,
//    in_ready=0; out_ready=1 -> beat drains and next beat loads the same edge.
//  5 N=3: FIXED sel=3 -> in_ready=0, out_valid falls to 0 after the last beat drains;
//    RR wrap from ch2 -> ch0.
//  6 Mode switch: RR accepts ch1 (ptr=2), switch to FIXED sel=0 for 3 beats, back to RR
//    with all valid -> first RR grant is ch2.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared constants for the N:1 channel multiplexer.
package chan_mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr, wrapping mod N.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          gnt_vld,
   output logic [SW-1:0] gnt_idx
);
   localparam logic [SW:0] NL = (SW+1)'(N);

   logic [N-1:0] w_rot;
   logic [SW:0]  w_off;
   logic [SW:0]  w_sum;

   // Rotating the doubled request vector puts ptr at bit 0, so the lowest set bit wins.
   always_comb begin
      w_rot   = N'({req, req} >> ptr);
      gnt_vld = 1'b0;
      w_off   = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (w_rot[i]) begin
            gnt_vld = 1'b1;
            w_off   = (SW+1)'(i);
         end
      end
      w_sum   = {1'b0, ptr} + w_off;
      gnt_idx = (w_sum >= NL) ? SW'(w_sum - NL) : SW'(w_sum);
   end
endmodule

// File: rtl/chan_mux_rr.sv
// N:1 channel mux with fixed or round-robin selection into one registered valid/ready stage.
module chan_mux_rr
   import chan_mux_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_chan,
   output logic           out_valid,
   input  logic           out_ready
);
   localparam int          NP = 1 << SW;
   localparam logic [SW:0] NL = (SW+1)'(N);

   logic [W-1:0]  r_data;
   logic [SW-1:0] r_chan;
   logic          r_valid;
   logic [SW-1:0] r_ptr;

   // Padded to a power of two so sel can index safely even when sel >= N.
   logic [W-1:0]  w_ch [NP];
   logic [NP-1:0] w_vld_pad;
   logic          w_rr_vld;
   logic [SW-1:0] w_rr_idx;
   logic          w_fix_vld;
   logic          w_gnt_vld;
   logic [SW-1:0] w_gnt;
   logic          w_take;
   logic          w_acc;

   for (genvar c = 0; c < NP; c++) begin : g_ch
      if (c < N) begin : g_real
         assign w_ch[c] = in_data[c*W +: W];
      end else begin : g_pad
         assign w_ch[c] = '0;
      end
   end

   assign w_vld_pad = NP'(in_valid);

   rr_arbiter #(.N(N)) u_arb (
      .req     (in_valid),
      .ptr     (r_ptr),
      .gnt_vld (w_rr_vld),
      .gnt_idx (w_rr_idx)
   );

   assign w_fix_vld = ({1'b0, sel} < NL) && w_vld_pad[sel];
   assign w_gnt_vld = (mode == MODE_RR) ? w_rr_vld : w_fix_vld;
   assign w_gnt     = (mode == MODE_RR) ? w_rr_idx : sel;
   assign w_take    = ~r_valid | out_ready;
   assign w_acc     = w_gnt_vld & w_take;
   assign in_ready  = w_acc ? (N'(1) << w_gnt) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
         r_ptr   <= '0;
      end else begin
         if (w_take) begin
            r_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
               r_data <= w_ch[w_gnt];
               r_chan <= w_gnt;
            end
         end
         if (w_acc && mode == MODE_RR)
            r_ptr <= (w_gnt == SW'(N-1)) ? '0 : w_gnt + 1'b1;
      end
   end

   assign out_data  = r_data;
   assign out_chan  = r_chan;
   assign out_valid = r_valid;
endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed bench for chan_mux_rr: an N=4 and an N=3 instance checked against a queue-free model.
module tb_chan_mux_rr;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [31:0] in_data = 32'h3CA55AC3;
   logic [3:0]  in_valid = 4'h0;
   logic        out_ready = 1'b1;

   logic [3:0]  rdy4;
   logic [7:0]  od4;
   logic [1:0]  oc4;
   logic        ov4;
   logic [2:0]  rdy3;
   logic [7:0]  od3;
   logic [1:0]  oc3;
   logic        ov3;

   int checks = 0;
   int failures = 0;

   bit         mv [2];
   logic [7:0] md [2];
   int         mc [2];
   int         mp [2];

   always #5 clk = ~clk;

   chan_mux_rr #(.N(4), .W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
      .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(out_ready)
   );

   chan_mux_rr #(.N(3), .W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
      .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(out_ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Plain search over channel indices; -1 means nobody is granted.
   function automatic int grant(input int n, input logic m, input int s,
                                input logic [3:0] v, input int p);
      if (!m) return (s < n && v[s]) ? s : -1;
      for (int k = 0; k < n; k++)
         if (v[(p + k) % n]) return (p + k) % n;
      return -1;
   endfunction

   function automatic int nn(input int d);
      return d ? 3 : 4;
   endfunction

   function automatic int gnt_d(input int d);
      return grant(nn(d), mode, int'(sel), d ? {1'b0, in_valid[2:0]} : in_valid, mp[d]);
   endfunction

   function automatic int exp_rdy(input int d);
      bit take;
      take = !mv[d] || out_ready;
      return (take && gnt_d(d) >= 0) ? (1 << gnt_d(d)) : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            mv[d] <= 1'b0; md[d] <= 8'h00; mc[d] <= 0; mp[d] <= 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (!mv[d] || out_ready) begin
               if (gnt_d(d) >= 0) begin
                  mv[d] <= 1'b1;
                  md[d] <= in_data[gnt_d(d)*8 +: 8];
                  mc[d] <= gnt_d(d);
                  if (mode) mp[d] <= (gnt_d(d) + 1) % nn(d);
               end else begin
                  mv[d] <= 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("ov4", 32'(ov4), 32'(mv[0]));
      if (mv[0]) begin
         chk("od4", 32'(od4), 32'(md[0]));
         chk("oc4", 32'(oc4), 32'(mc[0]));
      end
      chk("rdy4", 32'(rdy4), 32'(exp_rdy(0)));
      chk("ov3", 32'(ov3), 32'(mv[1]));
      if (mv[1]) begin
         chk("od3", 32'(od3), 32'(md[1]));
         chk("oc3", 32'(oc3), 32'(mc[1]));
      end
      chk("rdy3", 32'(rdy3), 32'(exp_rdy(1)));
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] hd;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ov", 32'(ov4), 32'd0);
      chk("rst_od", 32'(od4), 32'd0);
      chk("rst_oc", 32'(oc4), 32'd0);
      rst_n = 1'b1;

      // fixed select of channel 2
      mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
      cyc;
      chk("fix_od", 32'(od4), 32'hA5);
      chk("fix_oc", 32'(oc4), 32'd2);
      chk("fix_ov", 32'(ov4), 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("fix_rdy", 32'(rdy4), 32'b0100);
         cyc;
      end

      // round robin, all valid then only ch1/ch3
      mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = in_data + 32'h01010101;
         cyc;
         chk("rr_all", 32'(oc4), 32'(k % 4));
      end
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         cyc;
         chk("rr_13", 32'(oc4), (k % 2) ? 32'd3 : 32'd1);
      end

      // backpressure
      mode = 1'b0; sel = 2'd1; in_valid = 4'hF;
      hd = in_data[15:8];
      cyc;
      chk("bp_load", 32'(od4), 32'(hd));
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_data = in_data + 32'h01010101;
         cyc;
         chk("bp_od", 32'(od4), 32'(hd));
         chk("bp_oc", 32'(oc4), 32'd1);
         chk("bp_rdy", 32'(rdy4), 32'd0);
      end
      out_ready = 1'b1;
      hd = in_data[15:8];
      #1;
      chk("bp_rdy1", 32'(rdy4), 32'b0010);
      cyc;
      chk("bp_next", 32'(od4), 32'(hd));
      chk("bp_ov", 32'(ov4), 32'd1);

      // N=3: out-of-range sel, then rr wrap
      sel = 2'd3;
      cyc;
      chk("n3_ov0", 32'(ov3), 32'd0);
      chk("n3_rdy0", 32'(rdy3), 32'd0);
      cyc;
      chk("n3_ov0b", 32'(ov3), 32'd0);
      mode = 1'b1; in_valid = 4'b0100;
      cyc;
      chk("n3_c2", 32'(oc3), 32'd2);
      in_valid = 4'hF;
      cyc;
      chk("n3_wrap", 32'(oc3), 32'd0);

      // mode switch keeps the stored rr pointer
      in_valid = 4'b0010;
      cyc;
      chk("ms_c1", 32'(oc4), 32'd1);
      mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
      for (int k = 0; k < 3; k++) begin
         cyc;
         chk("ms_fix", 32'(oc4), 32'd0);
      end
      mode = 1'b1;
      cyc;
      chk("ms_rr", 32'(oc4), 32'd2);

      // asynchronous reset with a beat held
      chk("pre_rst_ov", 32'(ov4), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ov", 32'(ov4), 32'd0);
      chk("arst_od", 32'(od4), 32'd0);
      chk("arst_oc", 32'(oc4), 32'd0);
      chk("arst_ov3", 32'(ov3), 32'd0);
      cyc;
      rst_n = 1'b1;
      cyc;
      chk("post_rst", 32'(oc4), 32'd0);
      cyc;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
